// File: rtl/clint_pkg.sv
// CLINT address map, handshake state encoding and byte-merge helper.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME         = 16'hBFF8;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } clint_state_e;

  function automatic logic [63:0] merge_bytes(input logic [63:0] base,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
    logic [63:0] m;
    m = base;
    for (int b = 0; b < 8; b++) begin
      if (wstrb[b]) m[8*b +: 8] = wdata[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/hart_pkg.sv
// Shared hart-level definitions: interrupt lines presented to each hart's CSR unit.
package hart_pkg;

  typedef struct packed {
    logic mei;
    logic mti;
    logic msi;
  } hart_int;

endpackage

// File: rtl/clint_if.sv
// Request/response MMIO bus between the load/store unit (master) and the CLINT (slave).
interface clint_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_timebase.sv
// 64-bit mtime counter with bus write merge; optional prescaler under `CLINT_PRESCALER_EN
// (mtime advances once every TICK_DIV cycles).
module clint_timebase
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  output logic [63:0] mtime
);

  logic        tick;
  logic [63:0] mtime_inc;

`ifdef CLINT_PRESCALER_EN
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] div_q;

  assign tick = (div_q == CW'(TICK_DIV - 1));

  // A bus write to mtime restarts the prescaler phase.
  always_ff @(posedge clock) begin
    if (reset || wr_en || tick) div_q <= '0;
    else                        div_q <= div_q + 1'b1;
  end
`else
  // Free-running: TICK_DIV has no effect without the prescaler.
  localparam bit TICK_EVERY_CYCLE = 1'b1 | (TICK_DIV == 0);
  assign tick = TICK_EVERY_CYCLE;
`endif

  assign mtime_inc = mtime + {63'd0, tick};

  // Written bytes win; unwritten bytes carry the incremented value.
  always_ff @(posedge clock) begin
    if (reset)      mtime <= '0;
    else if (wr_en) mtime <= merge_bytes(mtime_inc, wr_data, wr_strb);
    else            mtime <= mtime_inc;
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip / mtimecmp / mtime MMIO registers and per-hart MEI/MTI/MSI.
// Build option: `define CLINT_PRESCALER_EN enables the TICK_DIV mtime prescaler.
module clint
  import clint_pkg::*;
  import hart_pkg::*;
#(
  parameter int NUM_HARTS = 1,
  parameter int TICK_DIV  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  clint_if.slave                  bus,
  input  logic [NUM_HARTS-1:0]    meip,
  output hart_int [NUM_HARTS-1:0] ext_int
);

  clint_state_e         state_q, state_d;
  logic                 accept, wr;
  logic [NUM_HARTS-1:0] sel_msip, sel_cmp;
  logic                 hit_mtime, hit_any;
  logic [63:0]          rdata_d, resp_rdata_q;
  logic                 resp_err_q;
  logic                 msip_strb, msip_bit;
  logic [63:0]          mtime;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, mti_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid)  state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
  end

  assign accept = bus.req_valid && (state_q == ST_IDLE);
  assign wr     = accept && bus.req_we;

  // msip words pack two harts per 8-byte lane pair, hence the word index at addr[15:2].
  always_comb begin
    sel_msip = '0;
    sel_cmp  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      sel_msip[h] = (bus.req_addr[15:2] == CLINT_MSIP_BASE[15:2] + 14'(h));
      sel_cmp[h]  = (bus.req_addr[15:3] == CLINT_MTIMECMP_BASE[15:3] + 13'(h));
    end
  end

  assign hit_mtime = (bus.req_addr[15:3] == CLINT_MTIME[15:3]);
  assign hit_any   = (|sel_msip) || (|sel_cmp) || hit_mtime;
  assign msip_strb = bus.req_addr[2] ? bus.req_wstrb[4]  : bus.req_wstrb[0];
  assign msip_bit  = bus.req_addr[2] ? bus.req_wdata[32] : bus.req_wdata[0];

  always_comb begin
    rdata_d = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel_msip[h]) rdata_d = bus.req_addr[2] ? {31'd0, msip_q[h], 32'd0} : {63'd0, msip_q[h]};
      if (sel_cmp[h])  rdata_d = mtimecmp_q[h];
    end
    if (hit_mtime) rdata_d = mtime;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      resp_rdata_q <= bus.req_we ? '0 : rdata_d;
      resp_err_q   <= !hit_any;
    end
  end

  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // MTI compares the current register values, so it lags its condition by one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      msip_q <= '0;
      mti_q  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && sel_msip[h] && msip_strb) msip_q[h] <= msip_bit;
        if (wr && sel_cmp[h])
          mtimecmp_q[h] <= merge_bytes(mtimecmp_q[h], bus.req_wdata, bus.req_wstrb);
        mti_q[h] <= (mtime >= mtimecmp_q[h]);
      end
    end
  end

  clint_timebase #(
    .TICK_DIV (TICK_DIV)
  ) u_timebase (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr && hit_mtime),
    .wr_data (bus.req_wdata),
    .wr_strb (bus.req_wstrb),
    .mtime   (mtime)
  );

  always_comb begin
    ext_int = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      ext_int[h].mei = meip[h];
      ext_int[h].mti = mti_q[h];
      ext_int[h].msi = msip_q[h];
    end
  end

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed timing scenarios plus randomized traffic vs. a time-based model.
`timescale 1ns/1ps
module tb_clint;
  import hart_pkg::*;

  localparam int NH = 2;
`ifdef CLINT_PRESCALER_EN
  localparam int TD = 4;
`else
  localparam int TD = 1;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NH-1:0]    meip  = '0;
  hart_int [NH-1:0] ext_int;

  clint_if bus();

  clint #(.NUM_HARTS(NH), .TICK_DIV(TD)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .meip    (meip),
    .ext_int (ext_int)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: mtime is a linear function of edge count since its last write (or reset).
  logic [63:0] mt_base, mt_base_prev;
  int unsigned mt_edge, mt_edge_prev;
  logic [63:0] cmp [NH];
  logic [63:0] cmp_prev [NH];
  int unsigned cmp_edge [NH];
  logic [NH-1:0] msip_m;
  int unsigned rst_edge;

  function automatic logic [63:0] mt_at(input int unsigned n);
    if (n >= mt_edge) return mt_base + 64'((n - mt_edge) / TD);
    return mt_base_prev + 64'((n - mt_edge_prev) / TD);
  endfunction

  function automatic logic exp_mti(input int h);
    int unsigned n;
    logic [63:0] c;
    if (cyc <= rst_edge) return 1'b0;
    n = cyc - 1;
    c = (n >= cmp_edge[h]) ? cmp[h] : cmp_prev[h];
    return mt_at(n) >= c;
  endfunction

  function automatic void model_reset();
    mt_base = '0; mt_base_prev = '0;
    mt_edge = rst_edge; mt_edge_prev = rst_edge;
    msip_m = '0;
    for (int h = 0; h < NH; h++) begin
      cmp[h] = '1; cmp_prev[h] = '1; cmp_edge[h] = rst_edge;
    end
  endfunction

  function automatic void model_apply(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                                      input logic [7:0] ws, input int unsigned acc,
                                      output logic [63:0] erd, output logic eer);
    logic [63:0] mask, nxt;
    int a, h, lane;
    for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{ws[b]}};
    a = int'(addr);
    erd = '0;
    eer = 1'b1;
    if (a < 4*NH) begin
      h = a / 4; lane = h % 2; eer = 1'b0;
      if (!we) erd = 64'(msip_m[h]) << (32*lane);
      else if (ws[4*lane]) msip_m[h] = wd[32*lane];
    end else if (a >= 'h4000 && a < 'h4000 + 8*NH) begin
      h = (a - 'h4000) / 8; eer = 1'b0;
      if (!we) erd = cmp[h];
      else begin
        cmp_prev[h] = cmp[h];
        cmp[h] = (cmp[h] & ~mask) | (wd & mask);
        cmp_edge[h] = acc;
      end
    end else if (a >= 'hBFF8 && a <= 'hBFFF) begin
      eer = 1'b0;
      if (!we) erd = mt_at(acc - 1);
      else begin
        nxt = mt_at(acc);
        mt_base_prev = mt_base; mt_edge_prev = mt_edge;
        mt_base = (nxt & ~mask) | (wd & mask);
        mt_edge = acc;
      end
    end
  endfunction

  task automatic apply_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.resp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rst_edge = cyc;
    model_reset();
  endtask

  // One full bus transaction; ei is ext_int sampled the cycle after acceptance.
  task automatic xact(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                      input logic [7:0] ws, input int hold,
                      output logic [63:0] rd, output logic er, output int unsigned acc,
                      output hart_int [NH-1:0] ei);
    int n;
    @(negedge clock);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    if (bus.req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_ready_wait got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_wstrb = ws; bus.resp_ready = (hold == 0);
    @(posedge clock); #1;
    acc = cyc;
    @(negedge clock);
    bus.req_valid = 1'b0;
    ei = ext_int;
    rd = bus.resp_rdata;
    er = bus.resp_err;
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_latency resp_valid got %b want 1 (addr %h)", bus.resp_valid, addr);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_rdata !== rd || bus.resp_err !== er) begin
        errors++;
        $display("FAIL resp_hold valid %b ready %b rdata %h err %b want 1 0 %h %b",
                 bus.resp_valid, bus.req_ready, bus.resp_rdata, bus.resp_err, rd, er);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    logic [63:0] rd, erd; logic er, eer; int unsigned acc; hart_int [NH-1:0] ei;
    apply_reset();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 64'd0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus valid %b ready %b rdata %h err %b want 0 1 0 0",
               bus.resp_valid, bus.req_ready, bus.resp_rdata, bus.resp_err);
    end
    for (int h = 0; h < NH; h++) begin
      checks++;
      if (ext_int[h].mti !== 1'b0 || ext_int[h].msi !== 1'b0) begin
        errors++;
        $display("FAIL reset_int hart %0d mti %b msi %b want 0 0", h, ext_int[h].mti, ext_int[h].msi);
      end
    end
    xact(1'b0, 16'hBFF8, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'hBFF8, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== erd || er !== eer || rd > 64'd8) begin
      errors++;
      $display("FAIL reset_mtime got %h err %b want %h err %b", rd, er, erd, eer);
    end
    xact(1'b0, 16'h4000, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'h4000, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_mtimecmp got %h err %b want ffffffffffffffff 0", rd, er);
    end
  endtask

  task automatic test_timer();
    logic [63:0] rd, erd; logic er, eer; int unsigned acc, wacc; hart_int [NH-1:0] ei;
    xact(1'b1, 16'h4000, 64'd100, 8'hFF, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h4000, 64'd100, 8'hFF, acc, erd, eer);
    xact(1'b1, 16'hBFF8, 64'd90, 8'hFF, 0, rd, er, wacc, ei);
    model_apply(1'b1, 16'hBFF8, 64'd90, 8'hFF, wacc, erd, eer);
    while (cyc < wacc + 10*TD + 4) begin
      @(negedge clock);
      checks++;
      if (ext_int[0].mti !== exp_mti(0)) begin
        errors++;
        $display("FAIL timer_rise_model edge+%0d mti %b want %b", cyc - wacc, ext_int[0].mti, exp_mti(0));
      end
      if (cyc == wacc + 10*TD) begin
        checks++;
        if (ext_int[0].mti !== 1'b0) begin errors++; $display("FAIL timer_rise_early mti %b want 0", ext_int[0].mti); end
      end
      if (cyc == wacc + 10*TD + 1) begin
        checks++;
        if (ext_int[0].mti !== 1'b1) begin errors++; $display("FAIL timer_rise_exact mti %b want 1", ext_int[0].mti); end
      end
    end
    xact(1'b1, 16'h4000, 64'd1000, 8'hFF, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h4000, 64'd1000, 8'hFF, acc, erd, eer);
    checks++;
    if (ei[0].mti !== 1'b1) begin errors++; $display("FAIL timer_fall_early mti %b want 1", ei[0].mti); end
    @(negedge clock);
    checks++;
    if (ext_int[0].mti !== 1'b0) begin errors++; $display("FAIL timer_fall_2edges mti %b want 0", ext_int[0].mti); end
  endtask

  task automatic test_msip();
    logic [63:0] rd, erd; logic er, eer; int unsigned acc; hart_int [NH-1:0] ei;
    xact(1'b1, 16'h0000, 64'hFFFF_FFFF, 8'h0F, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h0000, 64'hFFFF_FFFF, 8'h0F, acc, erd, eer);
    checks++;
    if (ei[0].msi !== 1'b1 || rd !== 64'd0 || er !== 1'b0) begin
      errors++; $display("FAIL msip_set msi %b rdata %h err %b want 1 0 0", ei[0].msi, rd, er);
    end
    xact(1'b0, 16'h0000, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'h0000, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== 64'h1) begin errors++; $display("FAIL msip_readback got %h want 1", rd); end
    xact(1'b1, 16'h0004, 64'hFFFF_FFFF_0000_0000, 8'hF0, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h0004, 64'hFFFF_FFFF_0000_0000, 8'hF0, acc, erd, eer);
    checks++;
    if (ei[1].msi !== 1'b1) begin errors++; $display("FAIL msip1_set msi %b want 1", ei[1].msi); end
    xact(1'b0, 16'h0004, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'h0004, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== 64'h1_0000_0000) begin errors++; $display("FAIL msip1_lane got %h want 100000000", rd); end
    xact(1'b1, 16'h0000, 64'd0, 8'hFF, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h0000, 64'd0, 8'hFF, acc, erd, eer);
    checks++;
    if (ei[0].msi !== 1'b0) begin errors++; $display("FAIL msip_clear msi %b want 0", ei[0].msi); end
  endtask

  task automatic test_wrap();
    logic [63:0] rd, erd; logic er, eer; int unsigned acc, wacc; hart_int [NH-1:0] ei;
    xact(1'b1, 16'h4000, 64'd5, 8'hFF, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h4000, 64'd5, 8'hFF, acc, erd, eer);
    xact(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd, er, wacc, ei);
    model_apply(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, wacc, erd, eer);
    while (cyc < wacc + 7*TD + 3) begin
      @(negedge clock);
      checks++;
      if (ext_int[0].mti !== exp_mti(0)) begin
        errors++;
        $display("FAIL wrap_model edge+%0d mti %b want %b", cyc - wacc, ext_int[0].mti, exp_mti(0));
      end
      if (cyc == wacc + 2*TD + 1) begin
        checks++;
        if (ext_int[0].mti !== 1'b0) begin errors++; $display("FAIL wrap_drop mti %b want 0", ext_int[0].mti); end
      end
      if (cyc == wacc + 7*TD + 1) begin
        checks++;
        if (ext_int[0].mti !== 1'b1) begin errors++; $display("FAIL wrap_reassert mti %b want 1", ext_int[0].mti); end
      end
    end
    xact(1'b0, 16'hBFF8, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'hBFF8, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== erd || rd > 64'd64) begin errors++; $display("FAIL wrap_read got %h want %h", rd, erd); end
  endtask

  task automatic test_unmapped_stall();
    logic [63:0] rd, erd; logic er, eer; int unsigned acc; hart_int [NH-1:0] ei;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h8000;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.resp_ready = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    // A write to msip[0] is now offered but must not be taken while the response stalls.
    bus.req_we = 1'b1; bus.req_addr = 16'h0000; bus.req_wdata = 64'd1; bus.req_wstrb = 8'hFF;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0) begin
      errors++; $display("FAIL unmapped_resp valid %b err %b rdata %h want 1 1 0",
                         bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    repeat (5) begin
      @(negedge clock);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0) begin
        errors++; $display("FAIL stall_hold valid %b ready %b err %b rdata %h want 1 0 1 0",
                           bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata);
      end
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    xact(1'b0, 16'h0000, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'h0000, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== erd || ei[0].msi !== msip_m[0]) begin
      errors++; $display("FAIL stall_no_accept msip %h msi %b want %h %b", rd, ei[0].msi, erd, msip_m[0]);
    end
    xact(1'b1, 16'h4010, 64'd7, 8'hFF, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h4010, 64'd7, 8'hFF, acc, erd, eer);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL unmapped_write err %b rdata %h want 1 0", er, rd); end
  endtask

  task automatic test_mid_reset();
    logic [63:0] rd, erd; logic er, eer; int unsigned acc; hart_int [NH-1:0] ei;
    xact(1'b1, 16'h0000, 64'd1, 8'h01, 0, rd, er, acc, ei);
    model_apply(1'b1, 16'h0000, 64'd1, 8'h01, acc, erd, eer);
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'hBFF8; bus.resp_ready = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rst_edge = cyc;
    model_reset();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || ext_int[0].msi !== 1'b0 || bus.resp_rdata !== 64'd0) begin
      errors++; $display("FAIL mid_reset valid %b ready %b msi %b rdata %h want 0 1 0 0",
                         bus.resp_valid, bus.req_ready, ext_int[0].msi, bus.resp_rdata);
    end
    bus.resp_ready = 1'b1;
    xact(1'b0, 16'h4000, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'h4000, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mid_reset_cmp got %h want all ones", rd); end
  endtask

  task automatic test_mei();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      meip = NH'($urandom);
      #1;
      for (int h = 0; h < NH; h++) begin
        checks++;
        if (ext_int[h].mei !== meip[h]) begin
          errors++; $display("FAIL mei_pass hart %0d got %b want %b", h, ext_int[h].mei, meip[h]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] addrs [10] = '{16'h0000, 16'h0004, 16'h4000, 16'h4008, 16'hBFF8,
                               16'h0008, 16'h4010, 16'h8000, 16'hBFF0, 16'hC000};
    logic [63:0] rd, erd, wd; logic er, eer, we; logic [15:0] addr; logic [7:0] ws;
    int unsigned acc; hart_int [NH-1:0] ei;
    for (int it = 0; it < 150; it++) begin
      addr = addrs[$urandom_range(0, 9)];
      we   = 1'($urandom);
      ws   = 8'($urandom);
      if ($urandom_range(0, 2) == 0) ws = 8'hFF;
      wd   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : mt_at(cyc) + 64'($urandom_range(0, 40));
      meip = NH'($urandom);
      xact(we, addr, wd, ws, $urandom_range(0, 2), rd, er, acc, ei);
      model_apply(we, addr, wd, ws, acc, erd, eer);
      checks++;
      if (rd !== erd || er !== eer) begin
        errors++; $display("FAIL rand_resp it %0d we %b addr %h rdata %h err %b want %h %b",
                           it, we, addr, rd, er, erd, eer);
      end
      @(negedge clock);
      for (int h = 0; h < NH; h++) begin
        checks++;
        if (ext_int[h].msi !== msip_m[h] || ext_int[h].mti !== exp_mti(h) || ext_int[h].mei !== meip[h]) begin
          errors++; $display("FAIL rand_int it %0d hart %0d got mei %b mti %b msi %b want %b %b %b",
                             it, h, ext_int[h].mei, ext_int[h].mti, ext_int[h].msi,
                             meip[h], exp_mti(h), msip_m[h]);
        end
      end
    end
  endtask

`ifdef CLINT_PRESCALER_EN
  task automatic test_prescaler();
    logic [63:0] rd, erd; logic er, eer; int unsigned acc; hart_int [NH-1:0] ei;
    apply_reset();
    while (cyc < rst_edge + 39) @(negedge clock);
    xact(1'b0, 16'hBFF8, '0, '0, 0, rd, er, acc, ei);
    model_apply(1'b0, 16'hBFF8, '0, '0, acc, erd, eer);
    checks++;
    if (rd !== 64'd10 || rd !== erd) begin errors++; $display("FAIL prescaler_40 got %h want a (model %h)", rd, erd); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timer();
    test_msip();
    test_wrap();
    test_unmapped_stall();
    test_mid_reset();
    test_mei();
    test_random();
`ifdef CLINT_PRESCALER_EN
    test_prescaler();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
